// File: rtl/hazard_pkg.sv
`default_nettype none
// ==========================================================================
// hazard_pkg : state encodings and control bundles for hazard_unit
// Rev 1.0
// ==========================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int LU_CNT_W = 4;

    typedef struct packed {
        logic buble;
        logic pc_w;
        logic ifid_w;
        logic flush;
        logic hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN    = '{buble: 1'b1, pc_w: 1'b1, ifid_w: 1'b1, flush: 1'b0, hold: 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{buble: 1'b0, pc_w: 1'b0, ifid_w: 1'b0, flush: 1'b0, hold: 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE = '{buble: 1'b1, pc_w: 1'b0, ifid_w: 1'b0, flush: 1'b0, hold: 1'b1};
    localparam hz_ctrl_t CTRL_BRANCH = '{buble: 1'b0, pc_w: 1'b1, ifid_w: 1'b1, flush: 1'b1, hold: 1'b0};
    localparam hz_ctrl_t CTRL_RESET  = '{buble: 1'b1, pc_w: 1'b0, ifid_w: 1'b0, flush: 1'b0, hold: 1'b0};

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ==========================================================================
// sat_counter : saturating up-counter with synchronous clear
// Rev 1.0
// ==========================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ==========================================================================
// hazard_unit : load-use / branch / memory-wait hazard controller (Mealy FSM)
// Rev 1.0
// ==========================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_mem_read,
    input  logic             beq_taken,
    input  logic             dm_busy,
    input  logic             stall_cnt_clr,
    output logic             buble_mux_ctrl,
    output logic             pc_w_enable,
    output logic             ifid_w_enable,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);

    hz_state_t             state, state_nxt;
    hz_state_t             ret_state, ret_nxt;
    hz_state_t             eff_state;
    logic [LU_CNT_W-1:0]   lu_cnt, lu_cnt_nxt;
    hz_ctrl_t              ctrl, ctrl_out;
    logic                  lu_hit;

    assign lu_hit = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            lu_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lu_cnt    <= lu_cnt_nxt;
        end
    end

    // The release cycle of MEM_WAIT behaves exactly like the saved state.
    assign eff_state = (state == ST_MEM_WAIT) ? ret_state : state;

    always_comb begin
        state_nxt  = state;
        ret_nxt    = ret_state;
        lu_cnt_nxt = lu_cnt;
        ctrl       = CTRL_RUN;
        if ((state == ST_MEM_WAIT) && dm_busy) begin
            ctrl = CTRL_FREEZE;
        end else if (eff_state == ST_LU_STALL) begin
            if (dm_busy) begin
                ctrl      = CTRL_FREEZE;
                ret_nxt   = ST_LU_STALL;
                state_nxt = ST_MEM_WAIT;
            end else begin
                ctrl       = CTRL_STALL;
                lu_cnt_nxt = lu_cnt - LU_CNT_W'(1);
                state_nxt  = (lu_cnt == LU_CNT_W'(1)) ? ST_RUN : ST_LU_STALL;
            end
        end else begin
            state_nxt = ST_RUN;
            if (dm_busy) begin
                ctrl      = CTRL_FREEZE;
                ret_nxt   = ST_RUN;
                state_nxt = ST_MEM_WAIT;
            end else if (beq_taken) begin
                ctrl = CTRL_BRANCH;
            end else if (lu_hit) begin
                ctrl       = CTRL_STALL;
                lu_cnt_nxt = LU_RELOAD;
                state_nxt  = (LU_RELOAD != '0) ? ST_LU_STALL : ST_RUN;
            end
        end
    end

    assign ctrl_out       = rst_n ? ctrl : CTRL_RESET;
    assign buble_mux_ctrl = ctrl_out.buble;
    assign pc_w_enable    = ctrl_out.pc_w;
    assign ifid_w_enable  = ctrl_out.ifid_w;
    assign ifid_flush     = ctrl_out.flush;
    assign pipe_hold      = ctrl_out.hold;
    assign hazard_state   = state;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl_out.pc_w),
        .clr   (stall_cnt_clr),
        .cnt   (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ==========================================================================
// tb_hazard_unit : directed self-checking bench, LU_STALL_CYCLES = 1 and 3
// Rev 1.0
// ==========================================================================
module tb_hazard_unit;

    localparam logic [4:0] C_RUN    = 5'b11100;
    localparam logic [4:0] C_STALL  = 5'b00000;
    localparam logic [4:0] C_FREEZE = 5'b10001;
    localparam logic [4:0] C_BRANCH = 5'b01110;
    localparam logic [4:0] C_RESET  = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        ifid_uses_rt, idex_mem_read, beq_taken, dm_busy, stall_cnt_clr;

    logic        bub1, pc1, ifw1, fl1, hd1;
    logic [1:0]  st1;
    logic [15:0] cnt1;
    logic        bub3, pc3, ifw3, fl3, hd3;
    logic [1:0]  st3;
    logic [15:0] cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
        .beq_taken(beq_taken), .dm_busy(dm_busy), .stall_cnt_clr(stall_cnt_clr),
        .buble_mux_ctrl(bub1), .pc_w_enable(pc1), .ifid_w_enable(ifw1),
        .ifid_flush(fl1), .pipe_hold(hd1), .hazard_state(st1), .stall_cnt(cnt1)
    );

    hazard_unit #(.LU_STALL_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_mem_read(idex_mem_read),
        .beq_taken(beq_taken), .dm_busy(dm_busy), .stall_cnt_clr(stall_cnt_clr),
        .buble_mux_ctrl(bub3), .pc_w_enable(pc3), .ifid_w_enable(ifw3),
        .ifid_flush(fl3), .pipe_hold(hd3), .hazard_state(st3), .stall_cnt(cnt3)
    );

    wire [4:0] ctl1 = {bub1, pc1, ifw1, fl1, hd1};
    wire [4:0] ctl3 = {bub3, pc3, ifw3, fl3, hd3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] xrt, input logic mr, input logic beq);
        ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
        idex_rt = xrt; idex_mem_read = mr; beq_taken = beq;
    endtask

    initial begin
        rst_n = 1'b0; dm_busy = 1'b0; stall_cnt_clr = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("reset_ctrl", ctl3, C_RESET);
        chk("reset_state", st3, 2'd0);
        chk("reset_cnt", cnt3, 16'd0);
        step(); step();
        rst_n = 1'b1;
        mid();
        chk("idle_run1", ctl1, C_RUN);
        chk("idle_run3", ctl3, C_RUN);

        // load-use on rs
        step(); drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        mid();
        chk("lu_a_ctl1", ctl1, C_STALL);
        chk("lu_a_ctl3", ctl3, C_STALL);
        chk("lu_a_st3", st3, 2'd0);
        step(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("lu_b_ctl1", ctl1, C_RUN);
        chk("lu_b_cnt1", cnt1, 16'd1);
        chk("lu_b_ctl3", ctl3, C_STALL);
        chk("lu_b_st3", st3, 2'd1);
        step(); mid();
        chk("lu_c_ctl3", ctl3, C_STALL);
        chk("lu_c_st3", st3, 2'd1);
        step(); mid();
        chk("lu_d_ctl3", ctl3, C_RUN);
        chk("lu_d_st3", st3, 2'd0);
        chk("lu_d_cnt3", cnt3, 16'd3);

        // no hazard: rt==0, and rt match without uses_rt
        step(); drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        mid();
        chk("rt0_ctl3", ctl3, C_RUN);
        step(); drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
        mid();
        chk("nouse_ctl3", ctl3, C_RUN);

        // branch beats load-use
        step(); drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        mid();
        chk("br_ctl3", ctl3, C_BRANCH);
        chk("br_ctl1", ctl1, C_BRANCH);
        step(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        mid();
        chk("br_after_st3", st3, 2'd0);
        chk("br_after_ctl3", ctl3, C_RUN);
        chk("br_cnt3", cnt3, 16'd3);

        // clear, then load-use via rt with 4-cycle dm_busy in the 2nd stall cycle
        step(); stall_cnt_clr = 1'b1;
        step(); stall_cnt_clr = 1'b0;
        mid();
        chk("clr_cnt3", cnt3, 16'd0);
        step(); drive(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0);
        mid();
        chk("mw0_ctl3", ctl3, C_STALL);
        step(); drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); dm_busy = 1'b1;
        mid();
        chk("mw1_ctl3", ctl3, C_FREEZE);
        chk("mw1_st3", st3, 2'd1);
        for (int i = 0; i < 3; i++) begin
            step(); mid();
            chk("mw_busy_ctl3", ctl3, C_FREEZE);
            chk("mw_busy_st3", st3, 2'd2);
        end
        step(); dm_busy = 1'b0;
        mid();
        chk("mw_rel_ctl3", ctl3, C_STALL);
        chk("mw_rel_st3", st3, 2'd2);
        step(); mid();
        chk("mw_last_ctl3", ctl3, C_STALL);
        chk("mw_last_st3", st3, 2'd1);
        step(); mid();
        chk("mw_done_ctl3", ctl3, C_RUN);
        chk("mw_done_st3", st3, 2'd0);
        chk("mw_cnt3", cnt3, 16'd7);
        chk("mw_cnt1", cnt1, 16'd5);

        // reset in the middle of MEM_WAIT
        step(); dm_busy = 1'b1;
        step(); step();
        mid();
        chk("rstmw_st3", st3, 2'd2);
        step(); rst_n = 1'b0;
        #1;
        chk("rstmw_ctl3", ctl3, C_RESET);
        chk("rstmw_st3_rst", st3, 2'd0);
        step(); rst_n = 1'b1; dm_busy = 1'b0;
        mid();
        chk("rstmw_after_st3", st3, 2'd0);
        chk("rstmw_after_ctl3", ctl3, C_RUN);
        chk("rstmw_after_cnt3", cnt3, 16'd0);

        // saturation by long dm_busy, then clear during a stall cycle
        step(); dm_busy = 1'b1;
        repeat (65534) step();
        mid();
        chk("sat_fffe", cnt3, 16'hFFFE);
        repeat (5) step();
        mid();
        chk("sat_ffff3", cnt3, 16'hFFFF);
        chk("sat_ffff1", cnt1, 16'hFFFF);
        chk("sat_freeze3", ctl3, C_FREEZE);
        step(); stall_cnt_clr = 1'b1;
        step(); stall_cnt_clr = 1'b0; dm_busy = 1'b0;
        mid();
        chk("sat_clr3", cnt3, 16'd0);
        chk("sat_rel_ctl3", ctl3, C_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
